// File: rtl/adder_serial.sv
// adder_serial: digit-serial add/subtract unit.
//
// Takes two WIDTH-bit operands plus carry/borrow-in and a mode bit over a
// valid/ready handshake, then walks the operands LSB first, DIGIT bits per
// cycle, through a single DIGIT-bit adder slice and a carry flop. The result
// (sum, carryout, signed overflow) is held on a valid/ready output.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready input handshake; operands sampled only on accept edge
//   input1, input2    operands A and B
//   carryin           add: carry-in, sub: borrow-in
//   sub               0 = A+B+carryin, 1 = A-B-carryin
//   out_valid/out_ready output handshake; result held until out_ready
//   sum               result mod 2^WIDTH
//   carryout          add: carry-out, sub: 1 = no borrow
//   overflow          two's-complement signed overflow
module adder_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             carryin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, b_q, sum_q;
  logic                   carry_q, carryout_q, overflow_q;
  logic [CW-1:0]          cnt_q;
  logic                   last;
  logic [DIGIT:0]         slice;
  logic [WIDTH+DIGIT-1:0] sum_cat;

  // Operands are shifted right each step, so the active slice always sits in
  // the low DIGIT bits; the result is shifted in from the top the same way,
  // landing in its final position after STEPS cycles.
  assign last    = (cnt_q == CW'(STEPS - 1));
  assign slice   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_q};
  assign sum_cat = {slice[DIGIT-1:0], sum_q};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = sum_q;
    carryout  = carryout_q;
    overflow  = overflow_q;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          // A - B - bin == A + ~B + ~bin
          a_q     <= input1;
          b_q     <= sub ? ~input2 : input2;
          carry_q <= carryin ^ sub;
          cnt_q   <= '0;
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          sum_q   <= sum_cat[WIDTH+DIGIT-1:DIGIT];
          carry_q <= slice[DIGIT];
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            carryout_q <= slice[DIGIT];
            // carry into MSB = a^b^s at the MSB, so ovf = a^b^s^cout
            overflow_q <= a_q[DIGIT-1] ^ b_q[DIGIT-1]
                        ^ slice[DIGIT-1] ^ slice[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_serial.sv
module tb_adder_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] input1, input2;
  logic       carryin, sub, out_ready;

  // index 0..3 -> DIGIT 1, 2, 4, 8
  logic       in_valid_v [4];
  logic       in_ready_v [4];
  logic       out_valid_v[4];
  logic       co_v       [4];
  logic       ov_v       [4];
  logic [7:0] sum_v      [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_serial #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .input1(input1), .input2(input2), .carryin(carryin), .sub(sub),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .sum(sum_v[0]),
    .carryout(co_v[0]), .overflow(ov_v[0]));

  adder_serial #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .input1(input1), .input2(input2), .carryin(carryin), .sub(sub),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .sum(sum_v[1]),
    .carryout(co_v[1]), .overflow(ov_v[1]));

  adder_serial #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .input1(input1), .input2(input2), .carryin(carryin), .sub(sub),
    .out_valid(out_valid_v[2]), .out_ready(out_ready), .sum(sum_v[2]),
    .carryout(co_v[2]), .overflow(ov_v[2]));

  adder_serial #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .input1(input1), .input2(input2), .carryin(carryin), .sub(sub),
    .out_valid(out_valid_v[3]), .out_ready(out_ready), .sum(sum_v[3]),
    .carryout(co_v[3]), .overflow(ov_v[3]));

  // Issue one op on instance idx, check latency and result, then drain it.
  task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sb, input logic [7:0] es,
                        input logic eco, input logic eov, input string name);
    int g;
    int lat;
    int steps;
    steps = 8 >> idx;
    g = 0;
    while (in_ready_v[idx] !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (g >= 50) begin
      bad++;
      $display("FAIL %s_ready: in_ready never rose", name);
    end
    @(negedge clk);
    input1 = a; input2 = b; carryin = ci; sub = sb;
    in_valid_v[idx] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[idx] = 1'b0;
    // scramble inputs after the accept edge; they must be ignored
    input1 = ~a; input2 = ~b; carryin = ~ci; sub = ~sb;
    lat = 0;
    while (out_valid_v[idx] !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat !== steps) begin
      bad++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, steps);
    end
    total++;
    if (sum_v[idx] !== es) begin
      bad++;
      $display("FAIL %s_sum: got %h want %h", name, sum_v[idx], es);
    end
    total++;
    if (co_v[idx] !== eco) begin
      bad++;
      $display("FAIL %s_carryout: got %b want %b", name, co_v[idx], eco);
    end
    total++;
    if (ov_v[idx] !== eov) begin
      bad++;
      $display("FAIL %s_overflow: got %b want %b", name, ov_v[idx], eov);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++;
    if (out_valid_v[idx] !== 1'b0 || in_ready_v[idx] !== 1'b1) begin
      bad++;
      $display("FAIL %s_drain: got out_valid=%b in_ready=%b want 0 1",
               name, out_valid_v[idx], in_ready_v[idx]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (in_ready_v[i] !== 1'b1 || out_valid_v[i] !== 1'b0 || sum_v[i] !== 8'h00
          || co_v[i] !== 1'b0 || ov_v[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_%0d: got rdy=%b vld=%b sum=%h co=%b ov=%b want 1 0 00 0 0",
                 i, in_ready_v[i], out_valid_v[i], sum_v[i], co_v[i], ov_v[i]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
    run_op(0, 8'h3C, 8'h0A, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, "add_3c_0a_c1");
    run_op(0, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "add_80_80");
  endtask

  task automatic test_sub();
    run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07");
    run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
    run_op(0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, "sub_00_00_b1");
    run_op(0, 8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, "sub_7f_ff");
  endtask

  task automatic test_digits();
    run_op(1, 8'hA5, 8'h5B, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "d2_add_a5_5b");
    run_op(2, 8'hA5, 8'h5B, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "d4_add_a5_5b");
    run_op(3, 8'hA5, 8'h5B, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "d8_add_a5_5b");
    run_op(1, 8'h40, 8'h40, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1, "d2_add_40_40_c1");
    run_op(2, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "d4_sub_05_07");
    run_op(3, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "d8_sub_80_01");
    run_op(2, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "d4_add_7f_01");
  endtask

  task automatic test_backpressure();
    int g;
    @(negedge clk);
    input1 = 8'h12; input2 = 8'h34; carryin = 1'b0; sub = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    g = 0;
    while (out_valid_v[0] !== 1'b1 && g < 40) begin
      @(posedge clk);
      #1;
      g++;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (out_valid_v[0] !== 1'b1 || sum_v[0] !== 8'h46 || in_ready_v[0] !== 1'b0
          || co_v[0] !== 1'b0 || ov_v[0] !== 1'b0) begin
        bad++;
        $display("FAIL hold_%0d: got vld=%b sum=%h rdy=%b co=%b ov=%b want 1 46 0 0 0",
                 c, out_valid_v[0], sum_v[0], in_ready_v[0], co_v[0], ov_v[0]);
      end
      if (c == 5) begin
        input1 = 8'hFF; input2 = 8'hFF; carryin = 1'b1;
        in_valid_v[0] = 1'b1;
      end
      if (c == 7) in_valid_v[0] = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    // the op pulsed during the hold must never produce a result
    g = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid_v[0] !== 1'b0) g++;
    end
    total++;
    if (g != 0) begin
      bad++;
      $display("FAIL hold_ghost: got %0d cycles of out_valid want 0", g);
    end
    run_op(0, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, "after_hold");
  endtask

  task automatic test_reset_mid_run();
    int g;
    @(negedge clk);
    input1 = 8'hFF; input2 = 8'h01; carryin = 1'b0; sub = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0 || sum_v[0] !== 8'h00
        || co_v[0] !== 1'b0 || ov_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset: got rdy=%b vld=%b sum=%h co=%b ov=%b want 1 0 00 0 0",
               in_ready_v[0], out_valid_v[0], sum_v[0], co_v[0], ov_v[0]);
    end
    g = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid_v[0] !== 1'b0) g++;
    end
    total++;
    if (g != 0) begin
      bad++;
      $display("FAIL midrun_discard: got %0d cycles of out_valid want 0", g);
    end
    run_op(0, 8'h3C, 8'h0A, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) in_valid_v[i] = 1'b0;
    input1 = '0; input2 = '0; carryin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_digits();
    test_backpressure();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
